// File: rtl/aes_core_scheduler_pkg.sv
// aes_core_scheduler_pkg: shared stage encodings, job length, FSM states and key-index bounds
package aes_core_scheduler_pkg;
    localparam int AES_STAGES = 40;
    localparam int KW = $clog2(AES_STAGES);
    localparam logic [3:0] KEY_FIRST = 4'd0;
    localparam logic [3:0] KEY_LAST = 4'd10;
    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_SHIFT = 2'b10,
        OP_MIX   = 2'b11
    } stage_op_e;
    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ISSUE,
        WAIT,
        RESULT
    } state_e;
endpackage

// File: rtl/aes_core_scheduler_if.sv
// aes_core_scheduler_if: requester, result and stage-core signals of the scheduler
interface aes_core_scheduler_if;
    logic         Req0;
    logic         Req1;
    logic         Dir0;
    logic         Dir1;
    logic [127:0] Din0;
    logic [127:0] Din1;
    logic         Gnt0;
    logic         Gnt1;
    logic [127:0] Dout;
    logic         DoutId;
    logic         DoutVld;
    logic         DoutErr;
    logic         DoutAck;
    logic         StageEn;
    logic [1:0]   StageOp;
    logic         StageInv;
    logic [3:0]   SelKey;
    logic [127:0] Text;
    logic         StageDone;
    logic [127:0] ModifiedText;
    modport master (
        input  Req0, Req1, Dir0, Dir1, Din0, Din1, DoutAck, StageDone, ModifiedText,
        output Gnt0, Gnt1, Dout, DoutId, DoutVld, DoutErr, StageEn, StageOp, StageInv, SelKey, Text
    );
    modport slave (
        output Req0, Req1, Dir0, Dir1, Din0, Din1, DoutAck, StageDone, ModifiedText,
        input  Gnt0, Gnt1, Dout, DoutId, DoutVld, DoutErr, StageEn, StageOp, StageInv, SelKey, Text
    );
endinterface

// File: rtl/aes_stage_rom.sv
// aes_stage_rom: maps stage index and direction to the core operation and the most recent round-key index
module aes_stage_rom
    import aes_core_scheduler_pkg::*;
(
    input  logic [KW-1:0] k,
    input  logic          dir,
    output stage_op_e     op,
    output logic [3:0]    sel_key
);
    logic [KW-1:0] idx;
    logic [3:0]    rnd;
    logic [1:0]    pos;
    logic          first;
    logic          enc_add;
    // after stage 0 the job is rounds of four slots; the last round drops its Mix slot
    always_comb begin
        idx = k - KW'(1);
        rnd = idx[KW-1:2];
        pos = idx[1:0];
        first = (k == '0);
        enc_add = (pos == 2'd3) || (rnd == 4'd9 && pos == 2'd2);
        op = first ? OP_ADD :
             dir   ? (pos == 2'd0 ? OP_SHIFT : pos == 2'd1 ? OP_SUB : pos == 2'd2 ? OP_ADD : OP_MIX) :
                     (pos == 2'd0 ? OP_SUB : pos == 2'd1 ? OP_SHIFT : enc_add ? OP_ADD : OP_MIX);
        sel_key = first ? (dir ? KEY_LAST : KEY_FIRST) :
                  dir   ? (pos[1] ? KEY_LAST - 4'd1 - rnd : KEY_LAST - rnd) :
                          (enc_add ? rnd + 4'd1 : rnd);
    end
endmodule

// File: rtl/aes_core_scheduler.sv
// aes_core_scheduler: round-robin arbiter sequencing two requesters' blocks through a shared AES stage core
module aes_core_scheduler
    import aes_core_scheduler_pkg::*;
#(
    parameter int STAGE_TIMEOUT = 16
) (
    input logic Clk,
    input logic Rst,
    aes_core_scheduler_if.master bus
);
    localparam int TW = $clog2(STAGE_TIMEOUT + 1);
    state_e        state;
    state_e        state_nxt;
    stage_op_e     op;
    logic [KW-1:0] k;
    logic [TW-1:0] wait_cnt;
    logic [127:0]  text;
    logic [3:0]    sel_key;
    logic          win;
    logic          win_nxt;
    logic          last;
    logic          owner;
    logic          inv;
    logic          err;
    logic          last_stage;
    logic          timeout;
    aes_stage_rom u_rom (
        .k      (k),
        .dir    (inv),
        .op     (op),
        .sel_key(sel_key)
    );
    assign win_nxt = (bus.Req0 && bus.Req1) ? ~last : bus.Req1;
    assign last_stage = (k == KW'(AES_STAGES - 1));
    assign timeout = (wait_cnt == TW'(STAGE_TIMEOUT - 1));
    assign bus.StageOp = op;
    assign bus.SelKey = sel_key;
    assign bus.StageInv = inv;
    assign bus.Text = text;
    assign bus.DoutId = owner;
    assign bus.DoutErr = (state == RESULT) && err;
    assign bus.Dout = (state == RESULT && !err) ? text : '0;
    // state register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else state <= state_nxt;
    end
    // next state and single-cycle strobes
    always_comb begin
        state_nxt = state;
        bus.Gnt0 = 1'b0;
        bus.Gnt1 = 1'b0;
        bus.StageEn = 1'b0;
        bus.DoutVld = 1'b0;
        case (state)
            IDLE: state_nxt = (bus.Req0 || bus.Req1) ? GRANT : IDLE;
            GRANT: begin
                bus.Gnt0 = ~win;
                bus.Gnt1 = win;
                state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.StageEn = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: state_nxt = bus.StageDone ? (last_stage ? RESULT : ISSUE) : (timeout ? RESULT : WAIT);
            RESULT: begin
                bus.DoutVld = 1'b1;
                state_nxt = bus.DoutAck ? IDLE : RESULT;
            end
            default: state_nxt = IDLE;
        endcase
    end
    // job datapath: winner, operand, stage counter and stall timer
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            k <= '0;
            wait_cnt <= '0;
            text <= '0;
            win <= 1'b0;
            last <= 1'b1;
            owner <= 1'b0;
            inv <= 1'b0;
            err <= 1'b0;
        end else begin
            case (state)
                IDLE: win <= win_nxt;
                GRANT: begin
                    text <= win ? bus.Din1 : bus.Din0;
                    inv <= win ? bus.Dir1 : bus.Dir0;
                    owner <= win;
                    last <= win;
                    k <= '0;
                    err <= 1'b0;
                end
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    if (bus.StageDone) begin
                        text <= bus.ModifiedText;
                        if (!last_stage) k <= k + KW'(1);
                    end else if (timeout) begin
                        err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_core_scheduler.sv
// tb_aes_core_scheduler: directed jobs against a reference AES stage core responder
module tb_aes_core_scheduler;
    import aes_core_scheduler_pkg::*;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    logic Clk;
    logic Rst;
    int n_cmp = 0;
    int n_bad = 0;
    int stall_k = -1;
    int stage_idx = 0;
    logic [7:0]   sbox [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk [11];
    logic [1:0]   trace_op [40];
    logic [3:0]   trace_sel [40];
    aes_core_scheduler_if bus ();
    aes_core_scheduler #(.STAGE_TIMEOUT(16)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
    function automatic logic [127:0] core_op(input logic [127:0] t, input logic [1:0] op, input logic inv, input logic [3:0] sel);
        logic [7:0]   b [16];
        logic [7:0]   o [16];
        logic [127:0] key_r;
        logic [127:0] res;
        key_r = rk[sel];
        for (int i = 0; i < 16; i++) b[i] = t[127-8*i -: 8];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                case (op)
                    2'b00: o[r+4*c] = b[r+4*c] ^ key_r[127-8*(r+4*c) -: 8];
                    2'b01: o[r+4*c] = inv ? isbox[b[r+4*c]] : sbox[b[r+4*c]];
                    2'b10: if (inv) o[r+4*((c+r)%4)] = b[r+4*c]; else o[r+4*c] = b[r+4*((c+r)%4)];
                    default: o[r+4*c] = inv ?
                        gmul(b[4*c+r], 8'h0e) ^ gmul(b[4*c+(r+1)%4], 8'h0b) ^ gmul(b[4*c+(r+2)%4], 8'h0d) ^ gmul(b[4*c+(r+3)%4], 8'h09) :
                        gmul(b[4*c+r], 8'h02) ^ gmul(b[4*c+(r+1)%4], 8'h03) ^ b[4*c+(r+2)%4] ^ b[4*c+(r+3)%4];
                endcase
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = o[i];
        return res;
    endfunction
    // reference stage core: answers each StageEn with a one-cycle StageDone in the following cycle
    initial begin
        logic [7:0]   iv;
        logic [7:0]   s;
        logic [7:0]   rr;
        logic [7:0]   rc;
        logic [31:0]  w [44];
        logic [31:0]  tw;
        logic [127:0] key_v;
        logic [127:0] res;
        for (int i = 0; i < 256; i++) begin
            iv = 8'h00;
            for (int j = 1; j < 256; j++) if (gmul(8'(i), 8'(j)) == 8'h01) iv = 8'(j);
            s = iv;
            rr = iv;
            for (int n = 0; n < 4; n++) begin
                rr = {rr[6:0], rr[7]};
                s ^= rr;
            end
            sbox[i] = s ^ 8'h63;
            isbox[s ^ 8'h63] = 8'(i);
        end
        key_v = KEY;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key_v[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {sbox[tw[23:16]], sbox[tw[15:8]], sbox[tw[7:0]], sbox[tw[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        bus.StageDone = 1'b0;
        bus.ModifiedText = '0;
        forever begin
            @(negedge Clk);
            if (bus.Gnt0 || bus.Gnt1) stage_idx = 0;
            if (bus.StageEn) begin
                if (stage_idx < 40) begin
                    trace_op[stage_idx] = bus.StageOp;
                    trace_sel[stage_idx] = bus.SelKey;
                end
                if (stage_idx != stall_k) begin
                    res = core_op(bus.Text, bus.StageOp, bus.StageInv, bus.SelKey);
                    @(posedge Clk);
                    #1;
                    bus.StageDone = 1'b1;
                    bus.ModifiedText = res;
                    @(posedge Clk);
                    #1;
                    bus.StageDone = 1'b0;
                end
                stage_idx++;
            end
        end
    end
    task automatic wait_gnt(output int id, output bit ok);
        ok = 1'b0;
        id = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (bus.Gnt0 || bus.Gnt1) begin
                id = bus.Gnt1 ? 1 : 0;
                ok = 1'b1;
                break;
            end
        end
    endtask
    task automatic wait_vld(output int cyc, output bit ok);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            cyc++;
            if (bus.DoutVld) begin
                ok = 1'b1;
                break;
            end
        end
    endtask
    task automatic do_ack;
        bus.DoutAck = 1'b1;
        @(negedge Clk);
        bus.DoutAck = 1'b0;
    endtask
    task automatic test_reset;
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if ({bus.Gnt0, bus.Gnt1, bus.DoutVld, bus.DoutErr, bus.StageEn} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_strobes: got %b want 00000", {bus.Gnt0, bus.Gnt1, bus.DoutVld, bus.DoutErr, bus.StageEn});
        end
        n_cmp++;
        if (bus.Text !== '0 || bus.Dout !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got text %h dout %h want 0", bus.Text, bus.Dout);
        end
        n_cmp++;
        if (bus.SelKey !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_selkey: got %0d want 0", bus.SelKey);
        end
        Rst = 1'b0;
        @(negedge Clk);
    endtask
    task automatic test_encrypt;
        int id;
        int cyc;
        bit ok;
        bus.Req0 = 1'b1;
        bus.Dir0 = 1'b0;
        bus.Din0 = PT;
        wait_gnt(id, ok);
        bus.Req0 = 1'b0;
        n_cmp++;
        if (!ok || id != 0) begin
            n_bad++;
            $display("FAIL enc_grant: got %0d want 0", id);
        end
        wait_vld(cyc, ok);
        n_cmp++;
        if (!ok || cyc != 81) begin
            n_bad++;
            $display("FAIL enc_latency: got %0d want 81", cyc);
        end
        n_cmp++;
        if (bus.Dout !== CT || bus.DoutId !== 1'b0 || bus.DoutErr !== 1'b0) begin
            n_bad++;
            $display("FAIL enc_result: got %h id %b err %b want %h id 0 err 0", bus.Dout, bus.DoutId, bus.DoutErr, CT);
        end
        n_cmp++;
        if ({trace_op[0], trace_sel[0], trace_op[3], trace_sel[3], trace_op[4], trace_sel[4], trace_op[39], trace_sel[39]} !==
            {2'b00, 4'd0, 2'b11, 4'd0, 2'b00, 4'd1, 2'b00, 4'd10}) begin
            n_bad++;
            $display("FAIL enc_trace: got k0 %0d/%0d k3 %0d/%0d k4 %0d/%0d k39 %0d/%0d want 0/0 3/0 0/1 0/10",
                     trace_op[0], trace_sel[0], trace_op[3], trace_sel[3], trace_op[4], trace_sel[4], trace_op[39], trace_sel[39]);
        end
        do_ack;
        n_cmp++;
        if (bus.DoutVld !== 1'b0) begin
            n_bad++;
            $display("FAIL enc_ack_clear: got %b want 0", bus.DoutVld);
        end
    endtask
    task automatic test_decrypt;
        int id;
        int cyc;
        bit ok;
        bus.Req1 = 1'b1;
        bus.Dir1 = 1'b1;
        bus.Din1 = CT;
        wait_gnt(id, ok);
        bus.Req1 = 1'b0;
        n_cmp++;
        if (!ok || id != 1) begin
            n_bad++;
            $display("FAIL dec_grant: got %0d want 1", id);
        end
        wait_vld(cyc, ok);
        n_cmp++;
        if (!ok || cyc != 81 || bus.Dout !== PT || bus.DoutId !== 1'b1) begin
            n_bad++;
            $display("FAIL dec_result: got cyc %0d %h id %b want 81 %h id 1", cyc, bus.Dout, bus.DoutId, PT);
        end
        n_cmp++;
        if ({trace_op[0], trace_sel[0], trace_op[1], trace_sel[1], trace_op[2], trace_sel[2], trace_op[3], trace_sel[3]} !==
            {2'b00, 4'd10, 2'b10, 4'd10, 2'b01, 4'd10, 2'b00, 4'd9}) begin
            n_bad++;
            $display("FAIL dec_trace_head: got %0d/%0d %0d/%0d %0d/%0d %0d/%0d want 0/10 2/10 1/10 0/9",
                     trace_op[0], trace_sel[0], trace_op[1], trace_sel[1], trace_op[2], trace_sel[2], trace_op[3], trace_sel[3]);
        end
        n_cmp++;
        if ({trace_op[4], trace_sel[4], trace_op[37], trace_sel[37], trace_op[38], trace_sel[38], trace_op[39], trace_sel[39]} !==
            {2'b11, 4'd9, 2'b10, 4'd1, 2'b01, 4'd1, 2'b00, 4'd0}) begin
            n_bad++;
            $display("FAIL dec_trace_tail: got %0d/%0d %0d/%0d %0d/%0d %0d/%0d want 3/9 2/1 1/1 0/0",
                     trace_op[4], trace_sel[4], trace_op[37], trace_sel[37], trace_op[38], trace_sel[38], trace_op[39], trace_sel[39]);
        end
        do_ack;
    endtask
    task automatic test_round_robin;
        int id;
        int cyc;
        bit ok;
        bus.Req0 = 1'b1;
        bus.Req1 = 1'b1;
        bus.Dir0 = 1'b0;
        bus.Dir1 = 1'b0;
        bus.Din0 = PT;
        bus.Din1 = PT;
        for (int j = 0; j < 4; j++) begin
            wait_gnt(id, ok);
            n_cmp++;
            if (!ok || id != j % 2) begin
                n_bad++;
                $display("FAIL rr_grant%0d: got %0d want %0d", j, id, j % 2);
            end
            wait_vld(cyc, ok);
            n_cmp++;
            if (!ok || bus.DoutId !== 1'(j % 2) || bus.Dout !== CT) begin
                n_bad++;
                $display("FAIL rr_result%0d: got id %b %h want id %0d %h", j, bus.DoutId, bus.Dout, j % 2, CT);
            end
            do_ack;
        end
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
    endtask
    task automatic test_timeout;
        int id;
        int cyc;
        bit ok;
        stall_k = 5;
        bus.Req0 = 1'b1;
        bus.Dir0 = 1'b0;
        bus.Din0 = PT;
        wait_gnt(id, ok);
        bus.Req0 = 1'b0;
        wait_vld(cyc, ok);
        n_cmp++;
        if (!ok || cyc != 28) begin
            n_bad++;
            $display("FAIL to_latency: got %0d want 28", cyc);
        end
        n_cmp++;
        if (bus.DoutErr !== 1'b1 || bus.Dout !== '0 || bus.DoutId !== 1'b0) begin
            n_bad++;
            $display("FAIL to_result: got err %b dout %h id %b want err 1 dout 0 id 0", bus.DoutErr, bus.Dout, bus.DoutId);
        end
        do_ack;
        stall_k = -1;
        bus.Req1 = 1'b1;
        bus.Dir1 = 1'b1;
        bus.Din1 = CT;
        wait_gnt(id, ok);
        bus.Req1 = 1'b0;
        wait_vld(cyc, ok);
        n_cmp++;
        if (!ok || cyc != 81 || bus.Dout !== PT || bus.DoutErr !== 1'b0 || bus.DoutId !== 1'b1) begin
            n_bad++;
            $display("FAIL to_recover: got cyc %0d %h err %b id %b want 81 %h err 0 id 1", cyc, bus.Dout, bus.DoutErr, bus.DoutId, PT);
        end
        do_ack;
    endtask
    task automatic test_reset_mid;
        int id;
        int cyc;
        bit ok;
        bit seen;
        bus.Req0 = 1'b1;
        bus.Dir0 = 1'b0;
        bus.Din0 = PT;
        wait_gnt(id, ok);
        bus.Req0 = 1'b0;
        repeat (41) @(negedge Clk);
        n_cmp++;
        if (bus.StageEn !== 1'b1 || bus.SelKey !== 4'd5 || bus.StageOp !== 2'b00) begin
            n_bad++;
            $display("FAIL mid_k20: got en %b sel %0d op %0d want en 1 sel 5 op 0", bus.StageEn, bus.SelKey, bus.StageOp);
        end
        #2;
        Rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.Gnt0, bus.Gnt1, bus.DoutVld, bus.DoutErr, bus.StageEn, bus.StageOp, bus.SelKey} !== 11'b0 ||
            bus.Text !== '0 || bus.Dout !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got en %b sel %0d op %0d text %h dout %h want all 0",
                     bus.StageEn, bus.SelKey, bus.StageOp, bus.Text, bus.Dout);
        end
        @(negedge Clk);
        Rst = 1'b0;
        seen = 1'b0;
        repeat (100) begin
            @(negedge Clk);
            if (bus.DoutVld) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_no_result: got %b want 0", seen);
        end
        bus.Req1 = 1'b1;
        bus.Dir1 = 1'b1;
        bus.Din1 = CT;
        wait_gnt(id, ok);
        bus.Req1 = 1'b0;
        wait_vld(cyc, ok);
        n_cmp++;
        if (!ok || id != 1 || cyc != 81 || bus.Dout !== PT || bus.DoutId !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_next_job: got gnt %0d cyc %0d %h id %b want 1 81 %h id 1", id, cyc, bus.Dout, bus.DoutId, PT);
        end
        do_ack;
    endtask
    task automatic test_ack_hold;
        int id;
        int cyc;
        bit ok;
        bit bad;
        bus.Req1 = 1'b1;
        bus.Dir1 = 1'b0;
        bus.Din1 = PT;
        wait_gnt(id, ok);
        bus.Req1 = 1'b0;
        bus.Req0 = 1'b1;
        bus.Dir0 = 1'b1;
        bus.Din0 = CT;
        repeat (20) @(negedge Clk);
        bus.DoutAck = 1'b1;
        repeat (3) @(negedge Clk);
        bus.DoutAck = 1'b0;
        wait_vld(cyc, ok);
        n_cmp++;
        if (!ok || cyc != 58 || bus.Dout !== CT || bus.DoutId !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_first: got cyc %0d %h id %b want 58 %h id 1", cyc, bus.Dout, bus.DoutId, CT);
        end
        bad = 1'b0;
        repeat (10) begin
            @(negedge Clk);
            if (!bus.DoutVld || bus.Dout !== CT || bus.DoutId !== 1'b1 || bus.Gnt0) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_stable: got unstable %b want 0", bad);
        end
        do_ack;
        n_cmp++;
        if (bus.DoutVld !== 1'b0 || bus.Gnt0 !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_release: got vld %b gnt0 %b want 0 0", bus.DoutVld, bus.Gnt0);
        end
        wait_gnt(id, ok);
        bus.Req0 = 1'b0;
        n_cmp++;
        if (!ok || id != 0) begin
            n_bad++;
            $display("FAIL hold_pending_grant: got %0d want 0", id);
        end
        wait_vld(cyc, ok);
        n_cmp++;
        if (!ok || cyc != 81 || bus.Dout !== PT || bus.DoutId !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_second: got cyc %0d %h id %b want 81 %h id 0", cyc, bus.Dout, bus.DoutId, PT);
        end
        do_ack;
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        Rst = 1'b1;
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        bus.Dir0 = 1'b0;
        bus.Dir1 = 1'b0;
        bus.Din0 = '0;
        bus.Din1 = '0;
        bus.DoutAck = 1'b0;
        test_reset;
        test_encrypt;
        test_decrypt;
        test_round_robin;
        test_timeout;
        test_reset_mid;
        test_ack_hold;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
